// File: rtl/snitch_icache_pkg.sv
// Shared types and constants for the instruction-cache event counter block.
package snitch_icache_pkg;

  // Per-fetch-port L0 event strobes (bit 0 is l0_miss).
  typedef struct packed {
    logic l0_stall;
    logic l0_double_hit;
    logic l0_prefetch;
    logic l0_hit;
    logic l0_miss;
  } icache_l0_events_t;

  // Shared L1 event strobes (bit 0 is l1_miss).
  typedef struct packed {
    logic l1_handler_stall;
    logic l1_stall;
    logic l1_hit;
    logic l1_miss;
  } icache_l1_events_t;

  localparam int unsigned ICACHE_EVT_NUM   = 9;
  localparam int unsigned ICACHE_EVT_IDX_W = 4;

  localparam int unsigned ICACHE_EVT_L0_MISS          = 0;
  localparam int unsigned ICACHE_EVT_L0_HIT           = 1;
  localparam int unsigned ICACHE_EVT_L0_PREFETCH      = 2;
  localparam int unsigned ICACHE_EVT_L0_DOUBLE_HIT    = 3;
  localparam int unsigned ICACHE_EVT_L0_STALL         = 4;
  localparam int unsigned ICACHE_EVT_L1_MISS          = 5;
  localparam int unsigned ICACHE_EVT_L1_HIT           = 6;
  localparam int unsigned ICACHE_EVT_L1_STALL         = 7;
  localparam int unsigned ICACHE_EVT_L1_HANDLER_STALL = 8;

  typedef enum logic [0:0] {
    StIdle,
    StResp
  } evt_rd_state_e;

endpackage

// File: rtl/snitch_icache_evt_cnt.sv
// Single event counter with sticky overflow flag.
// Build option: SNITCH_ICACHE_EVT_SATURATE_EN makes the counter saturate at all-ones
// instead of wrapping.
module snitch_icache_evt_cnt #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned INCR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic [INCR_WIDTH-1:0] incr,
  output logic [CNT_WIDTH-1:0]  q,
  output logic                  overflow
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH:0]   sum;

  // Extra top bit of the sum is the carry out.
  assign sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(incr);

  // Next-state: clear wins over counting; overflow flag is sticky.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      if (sum[CNT_WIDTH]) begin
        ovf_d = 1'b1;
      end
`ifdef SNITCH_ICACHE_EVT_SATURATE_EN
      cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
`else
      cnt_d = sum[CNT_WIDTH-1:0];
`endif
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign q        = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/snitch_icache_evt_counter.sv
// Aggregates per-port L0 and shared L1 instruction-cache events into nine counters and
// exposes them through a valid/ready read port with sticky overflow flags.
// Build option: SNITCH_ICACHE_EVT_SATURATE_EN (saturating counters, see snitch_icache_evt_cnt).
module snitch_icache_evt_counter
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
  input  icache_l1_events_t                      l1_events_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [ICACHE_EVT_IDX_W-1:0]            req_idx_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [CNT_WIDTH-1:0]                   rsp_data_o,
  output logic                                   rsp_err_o,
  output logic [ICACHE_EVT_NUM-1:0]              overflow_o
);

  localparam int unsigned IncrWidth = $clog2(NR_FETCH_PORTS + 1);

  logic [IncrWidth-1:0] incr [ICACHE_EVT_NUM];
  logic [CNT_WIDTH-1:0] cnt  [ICACHE_EVT_NUM];

  // Popcount each L0 field across all fetch ports; L1 strobes map straight to 0/1.
  always_comb begin
    for (int i = 0; i < ICACHE_EVT_NUM; i++) begin
      incr[i] = '0;
    end
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      incr[ICACHE_EVT_L0_MISS]       = incr[ICACHE_EVT_L0_MISS]
                                       + IncrWidth'(l0_events_i[p].l0_miss);
      incr[ICACHE_EVT_L0_HIT]        = incr[ICACHE_EVT_L0_HIT]
                                       + IncrWidth'(l0_events_i[p].l0_hit);
      incr[ICACHE_EVT_L0_PREFETCH]   = incr[ICACHE_EVT_L0_PREFETCH]
                                       + IncrWidth'(l0_events_i[p].l0_prefetch);
      incr[ICACHE_EVT_L0_DOUBLE_HIT] = incr[ICACHE_EVT_L0_DOUBLE_HIT]
                                       + IncrWidth'(l0_events_i[p].l0_double_hit);
      incr[ICACHE_EVT_L0_STALL]      = incr[ICACHE_EVT_L0_STALL]
                                       + IncrWidth'(l0_events_i[p].l0_stall);
    end
    incr[ICACHE_EVT_L1_MISS]          = IncrWidth'(l1_events_i.l1_miss);
    incr[ICACHE_EVT_L1_HIT]           = IncrWidth'(l1_events_i.l1_hit);
    incr[ICACHE_EVT_L1_STALL]         = IncrWidth'(l1_events_i.l1_stall);
    incr[ICACHE_EVT_L1_HANDLER_STALL] = IncrWidth'(l1_events_i.l1_handler_stall);
  end

  for (genvar i = 0; i < ICACHE_EVT_NUM; i++) begin : g_cnt
    snitch_icache_evt_cnt #(
      .CNT_WIDTH  (CNT_WIDTH),
      .INCR_WIDTH (IncrWidth)
    ) u_cnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .clear    (clear_i),
      .en       (enable_i),
      .incr     (incr[i]),
      .q        (cnt[i]),
      .overflow (overflow_o[i])
    );
  end

  evt_rd_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 req_fire;

  assign rsp_valid_o = (state_q == StResp);
  // A pending response being consumed frees the slot in the same cycle.
  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign req_fire    = req_valid_i & req_ready_o;

  // Read FSM next-state and response capture.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) state_d = StResp;
      end
      StResp: begin
        if (req_fire) begin
          state_d = StResp;
        end else if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (req_fire) begin
      if (req_idx_i < ICACHE_EVT_IDX_W'(ICACHE_EVT_NUM)) begin
        data_d = cnt[req_idx_i];
        err_d  = 1'b0;
      end else begin
        data_d = '0;
        err_d  = 1'b1;
      end
    end
  end

  // Read FSM and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_data_o = data_q;
  assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_snitch_icache_evt_counter.sv
// Self-checking bench for snitch_icache_evt_counter (8-bit counters, 4 fetch ports).
module tb_snitch_icache_evt_counter;
  import snitch_icache_pkg::*;

  localparam int unsigned NP  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned MAX = (1 << CW) - 1;
  localparam int unsigned L0W = NP * $bits(icache_l0_events_t);
`ifdef SNITCH_ICACHE_EVT_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic clear = 1'b0;
  icache_l0_events_t [NP-1:0] l0 = '0;
  icache_l1_events_t l1 = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_idx = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [CW-1:0] rsp_data;
  logic rsp_err;
  logic [8:0] ovf;

  int checks = 0;
  int errors = 0;

  snitch_icache_evt_counter #(
    .NR_FETCH_PORTS (NP),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (enable),
    .clear_i     (clear),
    .l0_events_i (l0),
    .l1_events_i (l1),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_idx_i   (req_idx),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer counts and a single response slot.
  int unsigned m_cnt [9];
  logic [8:0]  m_ovf;
  logic        m_valid;
  logic [CW-1:0] m_data;
  logic        m_err;

  function automatic int unsigned evt_count(input int i);
    int unsigned n = 0;
    if (i < 5) begin
      for (int p = 0; p < NP; p++) begin
        case (i)
          0: n += int'(l0[p].l0_miss);
          1: n += int'(l0[p].l0_hit);
          2: n += int'(l0[p].l0_prefetch);
          3: n += int'(l0[p].l0_double_hit);
          default: n += int'(l0[p].l0_stall);
        endcase
      end
    end else begin
      case (i)
        5: n = int'(l1.l1_miss);
        6: n = int'(l1.l1_hit);
        7: n = int'(l1.l1_stall);
        default: n = int'(l1.l1_handler_stall);
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) m_cnt[i] <= 0;
      m_ovf   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else begin
      if (req_valid && (!m_valid || rsp_ready)) begin
        m_valid <= 1'b1;
        if (int'(req_idx) < 9) begin
          m_data <= CW'(m_cnt[int'(req_idx)]);
          m_err  <= 1'b0;
        end else begin
          m_data <= '0;
          m_err  <= 1'b1;
        end
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 9; i++) m_cnt[i] <= 0;
        m_ovf <= '0;
      end else if (enable) begin
        for (int i = 0; i < 9; i++) begin
          int unsigned s;
          s = m_cnt[i] + evt_count(i);
          if (s > MAX) begin
            m_ovf[i] <= 1'b1;
            m_cnt[i] <= Sat ? MAX : s - (MAX + 1);
          end else begin
            m_cnt[i] <= s;
          end
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_data", 64'(rsp_data), 64'(m_data));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("req_ready", 64'(req_ready), 64'(!m_valid || rsp_ready));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int idx, output logic [CW-1:0] d, output logic e);
    req_valid = 1'b1;
    req_idx   = 4'(idx);
    rsp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("read_valid", 64'(rsp_valid), 64'd1);
    d = rsp_data;
    e = rsp_err;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
  endtask

  logic [CW-1:0] d;
  logic e;
  int unsigned exp_prev [9];

  initial begin
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Reset values
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // l0_miss on all ports for 10 cycles
    enable = 1'b1;
    for (int p = 0; p < NP; p++) l0[p].l0_miss = 1'b1;
    repeat (10) cyc();
    l0 = '0;
    do_read(0, d, e);
    chk("miss40_data", 64'(d), 64'd40);
    chk("miss40_err", 64'(e), 64'd0);
    chk("miss40_ovf", 64'(ovf), 64'd0);
    chk("model_miss40", 64'(m_cnt[0]), 64'd40);

    // l1_hit pulsed 5 cycles, read during the 6th pulse
    l1.l1_hit = 1'b1;
    repeat (5) cyc();
    do_read(6, d, e);
    chk("l1hit_first", 64'(d), 64'd5);
    l1 = '0;
    do_read(6, d, e);
    chk("l1hit_second", 64'(d), 64'd6);
    chk("model_l1hit", 64'(m_cnt[6]), 64'd6);

    // Clear while a response is stalled
    drain();
    req_valid = 1'b1;
    req_idx   = 4'd0;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("pend_data", 64'(rsp_data), 64'd40);
    clear = 1'b1;
    l0[0].l0_hit = 1'b1;
    l0[1].l0_hit = 1'b1;
    cyc();
    clear = 1'b0;
    l0 = '0;
    chk("pend_valid_after_clr", 64'(rsp_valid), 64'd1);
    chk("pend_data_after_clr", 64'(rsp_data), 64'd40);
    do_read(1, d, e);
    chk("hit_after_clr", 64'(d), 64'd0);
    do_read(0, d, e);
    chk("miss_after_clr", 64'(d), 64'd0);

    // l0_stall on all ports for 64 cycles overflows the 8-bit counter
    for (int p = 0; p < NP; p++) l0[p].l0_stall = 1'b1;
    repeat (64) cyc();
    l0 = '0;
    for (int p = 0; p < 3; p++) l0[p].l0_miss = 1'b1;
    l1.l1_miss = 1'b1;
    cyc();
    l0 = '0;
    cyc();
    l1 = '0;
    do_read(4, d, e);
    chk("stall_ovf_data", 64'(d), Sat ? 64'd255 : 64'd0);
    chk("stall_ovf_flag", 64'(ovf), 64'h010);
    chk("model_stall", 64'(m_cnt[4]), Sat ? 64'd255 : 64'd0);

    // Out-of-range index, then back-to-back reads
    do_read(12, d, e);
    chk("oor_data", 64'(d), 64'd0);
    chk("oor_err", 64'(e), 64'd1);
    req_valid = 1'b1;
    req_idx   = 4'd0;
    cyc();
    chk("b2b_first", 64'(rsp_data), 64'd3);
    chk("b2b_first_err", 64'(rsp_err), 64'd0);
    req_idx = 4'd5;
    cyc();
    chk("b2b_second", 64'(rsp_data), 64'd2);
    chk("b2b_second_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b0;
    cyc();

    // Disabled counting freezes every counter
    exp_prev = '{3, 0, 0, 0, Sat ? 255 : 0, 2, 0, 0, 0};
    enable = 1'b0;
    repeat (20) begin
      l0 = L0W'($urandom);
      l1 = 4'($urandom);
      cyc();
    end
    l0 = '0;
    l1 = '0;
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_read(i, d, e);
      chk($sformatf("frozen_%0d", i), 64'(d), 64'(exp_prev[i]));
    end

    // Reset during a pending response drops it at once
    drain();
    req_valid = 1'b1;
    req_idx   = 4'd2;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      l0        = L0W'($urandom);
      l1        = 4'($urandom);
      enable    = ($urandom % 8) != 0;
      clear     = ($urandom % 40) == 0;
      req_valid = ($urandom % 2) == 0;
      req_idx   = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 9);
      rsp_ready = ($urandom % 10) < 7;
      cyc();
    end
    clear = 1'b0;
    drain();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snitch_icache_evt_counter.md
# snitch_icache_evt_counter

Event-counter stage directly downstream of the instruction cache's event outputs. Accumulates the per-fetch-port L0 events and the shared L1 events into nine aggregate counters. Exposes them through a valid/ready read port, with sticky overflow flags, for the cluster peripheral/CSR logic.

## Interface
- `NR_FETCH_PORTS`, default 4, number of L0 event vectors (≥1).
- `CNT_WIDTH`, default 32, counter width in bits (8..64).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; the block uses one clock, and this reset is asynchronous and active-low.
- `enable_i`  in  1  counting enable; low freezes all counters.
- `clear_i`  in  1  synchronous clear of all counters and overflow flags.
- `l0_events_i`  in  `NR_FETCH_PORTS` × `icache_l0_events_t`  per-port L0 event strobes.
- `l1_events_i`  in  `icache_l1_events_t`  L1 event strobes.
- `req_valid_i`  in  1  read request valid.
- `req_ready_o`  out  1  read request ready.
- `req_idx_i`  in  4  counter index.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `rsp_data_o`  out  `CNT_WIDTH`  counter value.
- `rsp_err_o`  out  1  index out of range (≥9).
- `overflow_o`  out  9  sticky per-counter overflow flags.

## Operation
- Counter index map:
  - 0 `l0_miss`
  - 1 `l0_hit`
  - 2 `l0_prefetch`
  - 3 `l0_double_hit`
  - 4 `l0_stall`
  - 5 `l1_miss`
  - 6 `l1_hit`
  - 7 `l1_stall`
  - 8 `l1_handler_stall`
- L0 counters increment by the popcount of that field across all ports: 0..`NR_FETCH_PORTS` per cycle.
- The increment is zero-extended to `CNT_WIDTH`. The sum is computed in `CNT_WIDTH`+1 bits, and the carry indicates overflow.
- L1 counters increment by 0 or 1.
- Counting happens only when `enable_i`=1 and `clear_i`=0.
- Precedence is clear > count. When `clear_i`=1, all counters and `overflow_o` bits are 0 next cycle, and that cycle's events are discarded.
- Overflow: a counter's `overflow_o` bit is set on a carry out. It stays set until `clear_i` or reset. See Configuration for the counter value on overflow.
- Read port FSM:
  - IDLE: `rsp_valid_o`=0.
  - A request is accepted on `req_valid_i` & `req_ready_o`. The block latches the selected counter value and `rsp_err_o`, then moves to RESP.
  - RESP: `rsp_valid_o`=1 and the data is held stable until `rsp_ready_i`. On accept, go to IDLE, or stay in RESP if a new request is accepted in the same cycle.
  - `req_ready_o` = !`rsp_valid_o` | `rsp_ready_i`. This permits back-to-back reads at 1 per cycle.
- Out-of-range index: `rsp_data_o`=0 and `rsp_err_o`=1.
- `clear_i` does not affect a pending response. Response data already latched is returned unchanged.

## Timing
- Event in cycle N is visible in the counter register at N+1.
- Read accepted at cycle N returns, at N+1, the register value at N. This value excludes cycle-N events.
- Reset values:
  - all counters 0
  - `overflow_o`=0
  - `rsp_valid_o`=0
  - `rsp_data_o`=0
  - `rsp_err_o`=0
  - `req_ready_o`=1
- Reset asserted mid-response drops the response immediately (asynchronous).
- No combinational path from the event inputs to any output.
- `req_ready_o` depends combinationally on `rsp_ready_i` only.

## Configuration
- `SNITCH_ICACHE_EVT_SATURATE_EN` defined: a counter that would overflow holds at all-ones, and its `overflow_o` bit is set.
- Not defined: counters wrap modulo 2^`CNT_WIDTH`, and `overflow_o` is set on wrap.

## Structure
- In `snitch_icache_pkg`:
  - `ICACHE_EVT_NUM`=9
  - localparams `ICACHE_EVT_L0_MISS` … `ICACHE_EVT_L1_HANDLER_STALL` for the index map
  - `ICACHE_EVT_IDX_W`=4
- One sub-module, `snitch_icache_evt_cnt`: a single `CNT_WIDTH` counter with inputs `clear`, `en`, `incr[$clog2(NR_FETCH_PORTS+1)]`, and outputs `q` and `overflow`. It is instantiated 9 times.
- The top level contains the popcount logic and the read FSM.

## Test plan
- Reset, then hold `l0_miss` high on all 4 ports for 10 cycles with `enable_i`=1 → read idx 0 returns 40 with `rsp_err_o`=0. `overflow_o`=0.
- `l1_hit` pulsed 5 cycles, then read idx 6 in the same cycle as a 6th pulse → response 5. A second read returns 6.
- `clear_i` asserted in the same cycle as `l0_hit` on 2 ports, with a response pending and stalled by `rsp_ready_i`=0 → the pending data is unchanged. A subsequent read of idx 1 returns 0.
- `CNT_WIDTH`=8 with `l0_stall` on 4 ports for 64 cycles → with the macro, idx 4 reads 255 and `overflow_o[4]`=1. Without the macro, idx 4 reads 0 and `overflow_o[4]`=1.
- Read idx 12 → `rsp_data_o`=0, `rsp_err_o`=1. Then back-to-back reads of idx 0 and idx 5 with `rsp_ready_i`=1 → responses in consecutive cycles, in order.
- `enable_i`=0 while all events toggle for 20 cycles → every counter reads its previous value. `rst_ni` asserted while `rsp_valid_o`=1 → `rsp_valid_o` drops to 0 immediately.
